// File: rtl/fifo_chk_pkg.sv
// Shared types and constants for the FWFT FIFO read-side checker.
package fifo_chk_pkg;

  // Checker run state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Throttle LFSR: 16-bit Galois, x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam int unsigned       LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Width of a counter that must be able to hold the value 'limit'
  function automatic int unsigned wd_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/fifo_chk_lfsr.sv
// Free-running Galois LFSR used to throttle FIFO reads.
module fifo_chk_lfsr
  import fifo_chk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  // Shift right, folding the taps in whenever a one falls out of bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/fwft_fifo_checker.sv
// Read-side consumer/checker for a first-word-fall-through FIFO.
// Pops words, compares them against an incrementing sequence starting at SEED,
// and reports pass/fail, error count, first mismatch and a starvation watchdog.
// Optional feature macro: FIFO_CHK_THROTTLE_EN (random read backpressure via LFSR).
module fwft_fifo_checker
  import fifo_chk_pkg::*;
#(
  parameter int unsigned       DWIDTH  = 32,
  parameter int unsigned       CWIDTH  = 16,
  parameter logic [DWIDTH-1:0] SEED    = '0,
  parameter int unsigned       TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CWIDTH-1:0] num_words,
  input  logic              empty,
  input  logic [DWIDTH-1:0] dout,
  output logic              read,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CWIDTH-1:0] error_cnt,
  output logic [CWIDTH-1:0] words_rcvd,
  output logic [DWIDTH-1:0] first_exp,
  output logic [DWIDTH-1:0] first_got
);

  localparam int unsigned     WD_W    = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              pass_d, timeout_d;
  logic [CWIDTH-1:0] target_q;
  logic [DWIDTH-1:0] exp_q;
  logic              first_err_q;
  logic [WD_W-1:0]   wd_q;

  logic allow;
  logic pop;
  logic mismatch;
  logic last_pop;
  logic wd_fire;
  logic launch;

`ifdef FIFO_CHK_THROTTLE_EN
  logic [LFSR_W-1:0] lfsr;

  fifo_chk_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .lfsr (lfsr)
  );

  assign allow = lfsr[0];
`else
  assign allow = 1'b1;
`endif

  // Pop and compare decode; FWFT means dout is the word being popped this cycle
  assign pop      = (state_q == RUN) && !empty && allow;
  assign read     = pop;
  assign mismatch = pop && (dout != exp_q);
  assign last_pop = pop && (CWIDTH'(words_rcvd_q_plus1()) == target_q);
  assign wd_fire  = (TIMEOUT != 0) && (state_q == RUN) && !pop && (wd_q == WD_LAST);
  assign launch   = start && (state_q != RUN);

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  function automatic logic [CWIDTH-1:0] words_rcvd_q_plus1();
    return words_rcvd + CWIDTH'(1);
  endfunction

  // State register plus the status flags that change only on transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      pass    <= pass_d;
      timeout <= timeout_d;
    end
  end

  // Next-state and pass/timeout decisions
  always_comb begin
    state_d   = state_q;
    pass_d    = pass;
    timeout_d = timeout;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          timeout_d = 1'b0;
          if (num_words == '0) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
            pass_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (last_pop) begin
          state_d = DONE;
          pass_d  = (error_cnt == '0) && !mismatch;
        end else if (wd_fire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Run counters, expected-value tracker and first-mismatch capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      exp_q       <= '0;
      error_cnt   <= '0;
      words_rcvd  <= '0;
      first_exp   <= '0;
      first_got   <= '0;
      first_err_q <= 1'b0;
      wd_q        <= '0;
    end else if (launch) begin
      target_q    <= num_words;
      exp_q       <= SEED;
      error_cnt   <= '0;
      words_rcvd  <= '0;
      first_exp   <= '0;
      first_got   <= '0;
      first_err_q <= 1'b0;
      wd_q        <= '0;
    end else if (pop) begin
      words_rcvd <= words_rcvd + CWIDTH'(1);
      exp_q      <= exp_q + DWIDTH'(1);
      wd_q       <= '0;
      if (mismatch) begin
        if (error_cnt != '1) begin
          error_cnt <= error_cnt + CWIDTH'(1);
        end
        if (!first_err_q) begin
          first_err_q <= 1'b1;
          first_exp   <= exp_q;
          first_got   <= dout;
        end
      end
    end else if ((state_q == RUN) && (TIMEOUT != 0)) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

endmodule
